// File: rtl/fp16_argmax_ctrl_pkg.sv
// Shared FP16 field positions, special constants and controller state encoding.
package fp16_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 10;
  localparam int MANT_W   = 10;

  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [15:0] FP16_NEG_ZERO = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp16_argmax_ctrl_if.sv
// Scan control, sample stream and result handshake of the argmax controller.
interface fp16_argmax_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LEN    = 1024,
  parameter int IDX_W      = $clog2(MAX_LEN)
);
  logic                  start;
  logic                  mode_min;
  logic [IDX_W:0]        len;
  logic                  abort;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  busy;
  logic                  res_valid;
  logic                  res_empty;
  logic [DATA_WIDTH-1:0] res_value;
  logic [IDX_W-1:0]      res_index;
  logic                  res_ack;

  modport master (
    output start, mode_min, len, abort, in_valid, in_data, res_ack,
    input  in_ready, busy, res_valid, res_empty, res_value, res_index
  );

  modport slave (
    input  start, mode_min, len, abort, in_valid, in_data, res_ack,
    output in_ready, busy, res_valid, res_empty, res_value, res_index
  );
endinterface

// File: rtl/fp16_argmax_ctrl_gt.sv
// Combinational FP16 strict greater-than; NaN/Inf ordered by bit pattern.
module fp16_gt
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        gt
);

  logic              sign_a, sign_b;
  logic [4:0]        exp_a, exp_b;
  logic [MANT_W:0]   sig_a, sig_b;
  logic              mag_gt, mag_lt;

  assign sign_a = a[SIGN_BIT];
  assign sign_b = b[SIGN_BIT];
  assign exp_a  = a[EXP_MSB:EXP_LSB];
  assign exp_b  = b[EXP_MSB:EXP_LSB];
  // Hidden bit is set for every non-zero exponent (normals and Inf/NaN).
  assign sig_a  = {|exp_a, a[MANT_W-1:0]};
  assign sig_b  = {|exp_b, b[MANT_W-1:0]};

  assign mag_gt = (exp_a > exp_b) || ((exp_a == exp_b) && (sig_a > sig_b));
  assign mag_lt = (exp_a < exp_b) || ((exp_a == exp_b) && (sig_a < sig_b));

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gt = 1'b0;
    if (sign_a != sign_b) gt = sign_b;
    else if (!sign_a)     gt = mag_gt;
    else                  gt = mag_lt;
  end

endmodule

// File: rtl/fp16_argmax_ctrl.sv
// Streams N FP16 samples through one comparator; returns max/min value and first index.
module fp16_argmax_ctrl
  import fp16_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LEN    = 1024,
  parameter int IDX_W      = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  fp16_argmax_ctrl_if.slave  bus
);

  localparam logic [IDX_W:0] MAX_LEN_L = (IDX_W+1)'(MAX_LEN);

  state_t                state, state_nx;
  logic [IDX_W:0]        cnt, len_q, len_sat;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] best;
  logic [IDX_W-1:0]      best_idx;
  logic                  empty_q;
  logic                  start_ok, accept, last, cand_gt;
  logic [DATA_WIDTH-1:0] op_a, op_b;

  assign len_sat  = (bus.len > MAX_LEN_L) ? MAX_LEN_L : bus.len;
  assign start_ok = bus.start && !bus.abort && (state == IDLE || state == DONE);
  // abort masks the handshake even though in_ready is still shown.
  assign accept   = bus.in_valid && (state == SCAN) && !bus.abort;
  assign last     = (cnt == len_q - 1'b1);

  // Operands swap for argmin so the single comparator defines both orderings.
  assign op_a = mode_q ? best : bus.in_data;
  assign op_b = mode_q ? bus.in_data : best;

  fp16_gt u_gt (
    .a  (op_a),
    .b  (op_b),
    .gt (cand_gt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (len_sat == '0) ? DONE : SCAN;
      SCAN:    if (accept && last) state_nx = DONE;
      DONE: begin
        if (bus.start)        state_nx = (len_sat == '0) ? DONE : SCAN;
        else if (bus.res_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      len_q    <= '0;
      mode_q   <= 1'b0;
      best     <= FP16_POS_ZERO;
      best_idx <= '0;
      empty_q  <= 1'b0;
    end else if (bus.abort) begin
      empty_q  <= 1'b0;
    end else if (start_ok) begin
      cnt      <= '0;
      len_q    <= len_sat;
      mode_q   <= bus.mode_min;
      empty_q  <= (len_sat == '0);
      if (len_sat == '0) begin
        best     <= FP16_POS_ZERO;
        best_idx <= '0;
      end
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      if (cnt == '0 || cand_gt) begin
        best     <= bus.in_data;
        best_idx <= cnt[IDX_W-1:0];
      end
    end else if (state == DONE && bus.res_ack) begin
      empty_q  <= 1'b0;
    end
  end

  assign bus.in_ready  = (state == SCAN);
  assign bus.busy      = (state == SCAN);
  assign bus.res_valid = (state == DONE);
  assign bus.res_empty = empty_q;
  assign bus.res_value = best;
  assign bus.res_index = best_idx;

endmodule

// File: tb/tb_fp16_argmax_ctrl.sv
// Directed bench for fp16_argmax_ctrl with an expected-result scoreboard.
module tb_fp16_argmax_ctrl;

  localparam int MAX_LEN = 1024;
  localparam int IDX_W   = $clog2(MAX_LEN);

  typedef struct {
    logic [15:0]      value;
    logic [IDX_W-1:0] index;
    logic             empty;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [15:0] samp [MAX_LEN];
  logic [15:0] last_value;

  always #5 clk = ~clk;

  fp16_argmax_ctrl_if #(.DATA_WIDTH(16), .MAX_LEN(MAX_LEN)) bus ();

  fp16_argmax_ctrl #(.DATA_WIDTH(16), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference ordering: map each pattern to an unsigned key monotonic in FP16 value.
  function automatic logic [15:0] key(logic [15:0] x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

  function automatic bit m_gt(logic [15:0] a, logic [15:0] b);
    return key(a) > key(b);
  endfunction

  function automatic exp_t model(bit mode, int n);
    exp_t r;
    r.value = 16'h0000; r.index = '0; r.empty = (n == 0);
    if (n > 0) begin
      r.value = samp[0];
      for (int i = 1; i < n; i++)
        if (mode ? m_gt(r.value, samp[i]) : m_gt(samp[i], r.value)) begin
          r.value = samp[i];
          r.index = IDX_W'(i);
        end
    end
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_scan(bit mode, int n, bit push, bit with_ack);
    int eff;
    eff = (n > MAX_LEN) ? MAX_LEN : n;
    @(negedge clk);
    if (push) sb.push_back(model(mode, eff));
    bus.start = 1'b1; bus.mode_min = mode; bus.len = (IDX_W+1)'(n);
    bus.res_ack = with_ack;
    @(negedge clk);
    bus.start = 1'b0; bus.res_ack = 1'b0;
  endtask

  // Feeds samples 0..n_feed-1; when the scan completes, res_valid must be up one cycle after.
  task automatic feed(int n_total, int n_feed, bit bubbles);
    for (int i = 0; i < n_feed; i++) begin
      if (bubbles) begin
        bus.in_valid = 1'b0; bus.in_data = 16'(($urandom));
        @(negedge clk);
      end
      if (i == 0 || i == n_feed - 1) check("in_ready_scan", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1; bus.in_data = samp[i];
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    if (n_feed == n_total) check("latency", 32'(bus.res_valid), 32'd1);
  endtask

  task automatic wait_result(int budget);
    exp_t e;
    int k = 0;
    while (!bus.res_valid && k < budget) begin
      @(negedge clk); k++;
    end
    check("res_valid_wait", 32'(bus.res_valid), 32'd1);
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL scoreboard: observed result with no expected entry");
    end else begin
      e = sb.pop_front();
      check("res_value", 32'(bus.res_value), 32'(e.value));
      check("res_index", 32'(bus.res_index), 32'(e.index));
      check("res_empty", 32'(bus.res_empty), 32'(e.empty));
      last_value = e.value;
    end
  endtask

  task automatic ack();
    bus.res_ack = 1'b1;
    @(negedge clk);
    bus.res_ack = 1'b0;
    check("ack_drop", 32'(bus.res_valid), 32'd0);
    check("ack_hold", 32'(bus.res_value), 32'(last_value));
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"},  32'(bus.busy),      32'd0);
    check({tag, "_ready"}, 32'(bus.in_ready),  32'd0);
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_empty"}, 32'(bus.res_empty), 32'd0);
    check({tag, "_value"}, 32'(bus.res_value), 32'd0);
    check({tag, "_index"}, 32'(bus.res_index), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.mode_min = 1'b0; bus.len = '0; bus.abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Argmax over four samples.
    samp[0] = 16'h3C00; samp[1] = 16'h4000; samp[2] = 16'hBC00; samp[3] = 16'h3800;
    start_scan(1'b0, 4, 1'b1, 1'b0);
    feed(4, 4, 1'b0);
    wait_result(0);
    ack();

    // Argmin with bubbles between accepts.
    start_scan(1'b1, 4, 1'b1, 1'b0);
    feed(4, 4, 1'b1);
    wait_result(0);
    ack();

    // Ties keep the earliest index.
    samp[0] = 16'h3C00; samp[1] = 16'h3C00; samp[2] = 16'h0000;
    start_scan(1'b0, 3, 1'b1, 1'b0);
    feed(3, 3, 1'b0);
    wait_result(0);
    ack();

    // +0 beats -0.
    samp[0] = 16'h8000; samp[1] = 16'h0000;
    start_scan(1'b0, 2, 1'b1, 1'b0);
    feed(2, 2, 1'b0);
    wait_result(0);
    ack();

    // Empty scan goes straight to DONE without in_ready.
    start_scan(1'b0, 0, 1'b1, 1'b0);
    check("empty_no_ready", 32'(bus.in_ready), 32'd0);
    wait_result(0);
    ack();

    // Abort after two of five samples; the abort-cycle sample is masked.
    for (int i = 0; i < 5; i++) samp[i] = 16'h4000 + 16'(i);
    start_scan(1'b0, 5, 1'b0, 1'b0);
    feed(5, 2, 1'b0);
    bus.abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'h7C00;
    @(negedge clk);
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    check("abort_valid", 32'(bus.res_valid), 32'd0);
    check("abort_busy",  32'(bus.busy),      32'd0);
    repeat (2) @(negedge clk);
    check("abort_stay_idle", 32'(bus.res_valid), 32'd0);

    // Asynchronous reset mid-scan.
    start_scan(1'b0, 3, 1'b0, 1'b0);
    feed(3, 1, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    samp[0] = 16'h4400; samp[1] = 16'h4200;
    start_scan(1'b0, 2, 1'b1, 1'b0);
    feed(2, 2, 1'b0);
    wait_result(0);

    // Back-to-back full-length ramp: start and res_ack together in DONE.
    for (int i = 0; i < MAX_LEN; i++) samp[i] = 16'(i);
    start_scan(1'b0, MAX_LEN, 1'b1, 1'b1);
    check("b2b_valid_drop", 32'(bus.res_valid), 32'd0);
    check("b2b_busy",       32'(bus.busy),      32'd1);
    feed(MAX_LEN, MAX_LEN, 1'b0);
    wait_result(0);

    // Oversized len saturates to MAX_LEN.
    start_scan(1'b0, 1500, 1'b1, 1'b0);
    feed(MAX_LEN, MAX_LEN, 1'b0);
    wait_result(0);
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp16_argmax_ctrl.md
Name: fp16_argmax_ctrl

Overview:
- Sequences one FP16 greater-than comparator across a stream of N samples and returns the max or min value and the index of its first occurrence.
- Sits between the score buffer/stream source and the neuron-update/select logic.
- Replaces N-wide comparator trees where throughput of 1 sample/cycle is enough.

Parameters:
- DATA_WIDTH, 16, sample width; FP16 layout sign[15], exp[14:10], mant[9:0].
- MAX_LEN, 1024, maximum samples per scan.
- IDX_W, $clog2(MAX_LEN), width of index outputs.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a scan. Honoured only in IDLE or DONE.
- mode_min  in  1  sampled with start; 0 = argmax, 1 = argmin.
- len  in  IDX_W+1  sampled with start; number of samples, 0..MAX_LEN.
- abort  in  1  returns to IDLE from any state.
- in_valid  in  1  sample valid.
- in_data  in  DATA_WIDTH  FP16 sample.
- in_ready  out  1  high only in SCAN.
- busy  out  1  high in SCAN.
- res_valid  out  1  high in DONE.
- res_empty  out  1  in DONE: scan had len = 0.
- res_value  out  DATA_WIDTH  winning sample.
- res_index  out  IDX_W  index of the winning sample, 0-based.
- res_ack  in  1  consumes the result; DONE -> IDLE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - State = IDLE.
  - busy, in_ready, res_valid and res_empty = 0.
  - res_value = 0 and res_index = 0.
  - Count, best and mode registers = 0.
- Comparator function gt(a,b):
  - Returns 1 iff a > b. Equal bit patterns return 0.
  - Different signs: the positive operand is larger, so +0 (0x0000) > -0 (0x8000).
  - Same sign: compare biased exponent, then mantissa with hidden bit, with the sense inverted for negative operands.
  - No NaN or Inf special handling; these compare by bit pattern under the same rules.
- Candidate replaces best when:
  - mode_min = 0: gt(in_data, best) = 1.
  - mode_min = 1: gt(best, in_data) = 1.
  - Ties therefore keep the earliest index.
- IDLE:
  - start with len = 0: go to DONE next cycle with res_empty = 1 and res_value/res_index = 0.
  - start with len > 0: latch len and mode_min, clear cnt, go to SCAN.
- SCAN:
  - in_ready = 1. A sample is accepted on in_valid && in_ready.
  - Sample 0 loads best = in_data and best_idx = 0 unconditionally.
  - Later samples update best/best_idx by the rule above; cnt increments on each accept.
  - Bubbles (in_valid = 0) stall without side effects.
  - Accepting sample len-1 registers the final compare. Next cycle: DONE, res_valid = 1, outputs reflect all len samples.
  - Latency from the last accept to res_valid is 1 cycle.
- DONE:
  - res_* held stable until res_ack or start.
  - res_ack: go to IDLE next cycle. res_valid drops; res_value/res_index keep their last values.
  - start in DONE: behaves as start in IDLE (back-to-back scans); res_valid drops the next cycle.
  - start together with res_ack: start wins.
- start in SCAN is ignored.
- abort has priority over all other inputs in every state:
  - Next state IDLE; res_valid = 0 and res_empty = 0.
  - No sample is accepted in the abort cycle; in_ready is still shown, but the handshake is masked.
- len > MAX_LEN is saturated to MAX_LEN when latched.
- cnt is IDX_W+1 bits and must not wrap at len = MAX_LEN.
- Data path: one combinational comparator, one best register, one index register; no multicycle paths.

Decomposition:
- Package fp16_pkg:
  - FP16 field position constants (SIGN_BIT=15, EXP_MSB=14, EXP_LSB=10, MANT_W=10).
  - Constants FP16_POS_ZERO=16'h0000 and FP16_NEG_ZERO=16'h8000.
  - State enum: IDLE, SCAN, DONE.
- Sub-module fp16_gt: purely combinational gt(a,b) as defined above. It is instantiated once, with operands muxed by mode_min, so that future controllers reuse the same ordering.

Test Plan:
- Argmax: start with len=4, mode_min=0; samples 3C00, 4000, BC00, 3800 -> res_valid 1 cycle after the last accept; res_value=4000, res_index=1.
- Argmin with bubbles: the same samples with in_valid low on alternate cycles, mode_min=1 -> res_value=BC00, res_index=2; cnt is unaffected by bubbles.
- Ties and zeros:
  - argmax over 3C00, 3C00, 0000 -> res_index=0.
  - argmax over 8000, 0000 -> res_value=0000, res_index=1.
- Empty scan: start with len=0 -> DONE the next cycle; res_valid=1, res_empty=1, no in_ready pulse.
- Abort and reset:
  - abort after 2 of 5 samples -> IDLE next cycle, no res_valid.
  - rst_n low mid-SCAN -> all outputs 0 immediately.
  - A new len=2 scan (4400, 4200) then returns 4400 at index 0.
- Back-to-back: start asserted in DONE in the same cycle as res_ack, len=MAX_LEN with a ramp 0000..(MAX_LEN-1 as FP16 bits, positive) -> index MAX_LEN-1, cnt does not wrap.
